// File: rtl/uart_transceiver_param.sv
// Parameterised full-duplex UART: 16x oversampled TX and RX with optional
// parity, independent prescalers and a 2-flop receive synchronizer.
//
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   divisor              sys_clk cycles per oversample tick (0 acts as 1)
//   parity_mode          00 none, 01 even, 10 odd, 11 none
//   tx_data, tx_wr       word to send (LSB first) and send request
//   tx_busy, tx_done     frame in progress / end-of-last-stop-bit pulse
//   uart_tx, uart_rx     serial out (idle high) and asynchronous serial in
//   rx_data, rx_done     last received word and its one-cycle strobe
//   rx_frame_err         stop bit sampled low (qualified by rx_done)
//   rx_parity_err        parity mismatch (qualified by rx_done)
module uart_transceiver_param #(
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 16,
    parameter int STOP_BITS = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DIV_W-1:0]  divisor,
    input  logic [1:0]        parity_mode,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_wr,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              uart_tx,
    input  logic              uart_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              rx_frame_err,
    output logic              rx_parity_err
);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    logic [DIV_W-1:0] div_m1;

    // A divisor of 0 reloads to 0, i.e. one tick per cycle like divisor 1.
    assign div_m1 = (divisor == '0) ? '0 : divisor - DIV_W'(1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [DIV_W-1:0]  tx_pre_q, tx_pre_d;
    logic [3:0]        tx_tick_q, tx_tick_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shreg_q, tx_shreg_d;
    logic              tx_par_en_q, tx_par_en_d;
    logic              tx_par_q, tx_par_d;

    logic tx_tick;
    logic tx_bit_end;
    logic tx_last_data;
    logic tx_last_stop;

    assign tx_tick      = (tx_pre_q == '0);
    assign tx_bit_end   = tx_tick && (tx_tick_q == 4'd15);
    assign tx_last_data = (tx_bit_q == 4'(DATA_W - 1));
    assign tx_last_stop = (tx_bit_q == 4'(STOP_BITS - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_pre_q    <= '0;
            tx_tick_q   <= '0;
            tx_bit_q    <= '0;
            tx_shreg_q  <= '0;
            tx_par_en_q <= 1'b0;
            tx_par_q    <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_pre_q    <= tx_pre_d;
            tx_tick_q   <= tx_tick_d;
            tx_bit_q    <= tx_bit_d;
            tx_shreg_q  <= tx_shreg_d;
            tx_par_en_q <= tx_par_en_d;
            tx_par_q    <= tx_par_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_wr) tx_state_d = TX_START;
            end
            TX_START: begin
                if (tx_bit_end) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                if (tx_bit_end && tx_last_data)
                    tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                if (tx_bit_end) tx_state_d = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end && tx_last_stop) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_pre_d    = tx_pre_q;
        tx_tick_d   = tx_tick_q;
        tx_bit_d    = tx_bit_q;
        tx_shreg_d  = tx_shreg_q;
        tx_par_en_d = tx_par_en_q;
        tx_par_d    = tx_par_q;
        if (tx_state_q == TX_IDLE) begin
            tx_pre_d  = '0;
            tx_tick_d = '0;
            tx_bit_d  = '0;
            if (tx_wr) begin
                tx_pre_d    = div_m1;
                tx_shreg_d  = tx_data;
                tx_par_en_d = parity_mode[0] ^ parity_mode[1];
                tx_par_d    = (^tx_data) ^ (parity_mode == 2'b10);
            end
        end else begin
            tx_pre_d = tx_tick ? div_m1 : tx_pre_q - DIV_W'(1);
            if (tx_tick) tx_tick_d = tx_tick_q + 4'd1;
            if (tx_bit_end) begin
                // bit counter indexes data bits, then stop bits
                if (tx_state_q == TX_DATA) begin
                    tx_shreg_d = tx_shreg_q >> 1;
                    tx_bit_d   = tx_last_data ? 4'd0 : tx_bit_q + 4'd1;
                end else if (tx_state_q == TX_STOP) begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end else begin
                    tx_bit_d = 4'd0;
                end
            end
        end
    end

    always_comb begin
        uart_tx = 1'b1;
        unique case (tx_state_q)
            TX_IDLE:   uart_tx = 1'b1;
            TX_START:  uart_tx = 1'b0;
            TX_DATA:   uart_tx = tx_shreg_q[0];
            TX_PARITY: uart_tx = tx_par_q;
            TX_STOP:   uart_tx = 1'b1;
            default:   uart_tx = 1'b1;
        endcase
        tx_busy = (tx_state_q != TX_IDLE);
        tx_done = (tx_state_q == TX_STOP) && tx_bit_end && tx_last_stop;
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_s1_q, rx_s2_q, rx_s3_q;

    rx_state_e         rx_state_q, rx_state_d;
    logic [DIV_W-1:0]  rx_pre_q, rx_pre_d;
    logic [3:0]        rx_tick_q, rx_tick_d;
    logic [3:0]        rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shreg_q, rx_shreg_d;
    logic              rx_par_en_q, rx_par_en_d;
    logic              rx_par_odd_q, rx_par_odd_d;
    logic              rx_par_bit_q, rx_par_bit_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_done_q, rx_done_d;
    logic              rx_ferr_q, rx_ferr_d;
    logic              rx_perr_q, rx_perr_d;

    logic rx_fall;
    logic rx_tick;
    logic rx_sample;
    logic rx_bit_end;
    logic rx_last_data;

    // s3 is only the previous synchronized value, used for edge detect
    assign rx_fall      = rx_s3_q & ~rx_s2_q;
    assign rx_tick      = (rx_pre_q == '0);
    assign rx_sample    = rx_tick && (rx_tick_q == 4'd7);
    assign rx_bit_end   = rx_tick && (rx_tick_q == 4'd15);
    assign rx_last_data = (rx_bit_q == 4'(DATA_W - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_s3_q      <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_pre_q     <= '0;
            rx_tick_q    <= '0;
            rx_bit_q     <= '0;
            rx_shreg_q   <= '0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_par_bit_q <= 1'b0;
            rx_data_q    <= '0;
            rx_done_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_perr_q    <= 1'b0;
        end else begin
            rx_s1_q      <= uart_rx;
            rx_s2_q      <= rx_s1_q;
            rx_s3_q      <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            rx_pre_q     <= rx_pre_d;
            rx_tick_q    <= rx_tick_d;
            rx_bit_q     <= rx_bit_d;
            rx_shreg_q   <= rx_shreg_d;
            rx_par_en_q  <= rx_par_en_d;
            rx_par_odd_q <= rx_par_odd_d;
            rx_par_bit_q <= rx_par_bit_d;
            rx_data_q    <= rx_data_d;
            rx_done_q    <= rx_done_d;
            rx_ferr_q    <= rx_ferr_d;
            rx_perr_q    <= rx_perr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_sample && rx_s2_q) rx_state_d = RX_IDLE;
                else if (rx_bit_end)      rx_state_d = RX_DATA;
            end
            RX_DATA: begin
                if (rx_bit_end && rx_last_data)
                    rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (rx_bit_end) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                // re-arm mid stop bit; a low stop bit waits out the break
                if (rx_sample)
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_WAIT_HIGH;
            end
            RX_WAIT_HIGH: begin
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_pre_d     = rx_pre_q;
        rx_tick_d    = rx_tick_q;
        rx_bit_d     = rx_bit_q;
        rx_shreg_d   = rx_shreg_q;
        rx_par_en_d  = rx_par_en_q;
        rx_par_odd_d = rx_par_odd_q;
        rx_par_bit_d = rx_par_bit_q;
        rx_data_d    = rx_data_q;
        rx_done_d    = 1'b0;
        rx_ferr_d    = 1'b0;
        rx_perr_d    = 1'b0;
        if (rx_state_q == RX_IDLE || rx_state_q == RX_WAIT_HIGH) begin
            rx_pre_d  = '0;
            rx_tick_d = '0;
            rx_bit_d  = '0;
            if (rx_state_q == RX_IDLE && rx_fall) begin
                rx_pre_d     = div_m1;
                rx_par_en_d  = parity_mode[0] ^ parity_mode[1];
                rx_par_odd_d = parity_mode[1];
            end
        end else begin
            rx_pre_d = rx_tick ? div_m1 : rx_pre_q - DIV_W'(1);
            if (rx_tick) rx_tick_d = rx_tick_q + 4'd1;
            if (rx_sample) begin
                if (rx_state_q == RX_DATA) begin
                    rx_shreg_d = {rx_s2_q, rx_shreg_q[DATA_W-1:1]};
                end else if (rx_state_q == RX_PARITY) begin
                    rx_par_bit_d = rx_s2_q;
                end else if (rx_state_q == RX_STOP) begin
                    rx_data_d = rx_shreg_q;
                    rx_done_d = 1'b1;
                    rx_ferr_d = ~rx_s2_q;
                    rx_perr_d = rx_par_en_q &
                                (rx_par_bit_q ^ (^rx_shreg_q) ^ rx_par_odd_q);
                end
            end
            if (rx_bit_end && rx_state_q == RX_DATA)
                rx_bit_d = rx_last_data ? 4'd0 : rx_bit_q + 4'd1;
        end
    end

    always_comb begin
        rx_data       = rx_data_q;
        rx_done       = rx_done_q;
        rx_frame_err  = rx_ferr_q;
        rx_parity_err = rx_perr_q;
    end

endmodule

// File: tb/tb_uart_transceiver_param.sv
// Directed bench for uart_transceiver_param: loopback frame table plus
// hand-driven RX corner cases, back-to-back TX and mid-frame reset.
module tb_uart_transceiver_param;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [15:0] divisor;
    logic [1:0]  parity_mode;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic        tx_done;
    logic        uart_tx;
    logic        uart_rx;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_frame_err;
    logic        rx_parity_err;

    logic lb;
    logic rx_drv;

    assign uart_rx = lb ? uart_tx : rx_drv;

    uart_transceiver_param #(
        .DATA_W(8), .DIV_W(16), .STOP_BITS(1)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .divisor(divisor),
        .parity_mode(parity_mode),
        .tx_data(tx_data),
        .tx_wr(tx_wr),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    int         rx_cnt = 0;
    int         tx_cnt = 0;
    logic [7:0] rx_last = '0;
    logic       rx_pe = 1'b0;
    logic       rx_fe = 1'b0;

    always @(negedge sys_clk) begin
        if (rx_done) begin
            rx_cnt  <= rx_cnt + 1;
            rx_last <= rx_data;
            rx_pe   <= rx_parity_err;
            rx_fe   <= rx_frame_err;
        end
        if (tx_done) tx_cnt <= tx_cnt + 1;
    end

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  mode;
        logic [10:0] frame;
        int          nb;
    } vec_t;

    vec_t vt[10];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Called in the first cycle of a frame (start bit on the line).
    task automatic watch_tx(input logic [10:0] fr, input int nb,
                            input int bl, input logic [7:0] exp_rx,
                            input bit chg);
        int done_n;
        int done_at;
        int busy_bad;
        int rx0;
        done_n   = 0;
        done_at  = -1;
        busy_bad = 0;
        rx0      = rx_cnt;
        for (int c = 0; c < nb * bl; c++) begin
            if (chg && c == 100) begin
                tx_data     = 8'h35;
                parity_mode = 2'b01;
            end
            if (c % bl == bl / 2)
                chk($sformatf("tx_bit%0d", c / bl), 32'(uart_tx),
                    32'(fr[c / bl]));
            if (tx_busy !== 1'b1) busy_bad++;
            if (tx_done === 1'b1) begin
                done_n++;
                done_at = c;
            end
            tick();
        end
        chk("busy_fall", 32'(tx_busy), 32'd0);
        chk("busy_held", 32'(busy_bad), 32'd0);
        chk("tx_done_n", 32'(done_n), 32'd1);
        chk("tx_done_at", 32'(done_at), 32'(nb * bl - 1));
        chk("rx_done_n", 32'(rx_cnt - rx0), 32'd1);
        chk("rx_word", 32'(rx_last), 32'(exp_rx));
        chk("rx_perr", 32'(rx_pe), 32'd0);
        chk("rx_ferr", 32'(rx_fe), 32'd0);
        chk("rx_hold", 32'(rx_data), 32'(exp_rx));
    endtask

    task automatic drive_rx(input logic [10:0] fr, input int nb);
        for (int i = 0; i < nb; i++) begin
            rx_drv = fr[i];
            repeat (48) tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0;
        int tx0;

        vt[0] = '{8'h4A, 2'b00, {1'b1, 8'h4A, 1'b0}, 10};
        vt[1] = '{8'h4A, 2'b01, {1'b1, 1'b1, 8'h4A, 1'b0}, 11};
        vt[2] = '{8'h4A, 2'b10, {1'b1, 1'b0, 8'h4A, 1'b0}, 11};
        vt[3] = '{8'hA5, 2'b01, {1'b1, 1'b0, 8'hA5, 1'b0}, 11};
        vt[4] = '{8'hA5, 2'b10, {1'b1, 1'b1, 8'hA5, 1'b0}, 11};
        vt[5] = '{8'h00, 2'b01, {1'b1, 1'b0, 8'h00, 1'b0}, 11};
        vt[6] = '{8'hFF, 2'b10, {1'b1, 1'b1, 8'hFF, 1'b0}, 11};
        vt[7] = '{8'h01, 2'b11, {1'b1, 8'h01, 1'b0}, 10};
        vt[8] = '{8'h80, 2'b01, {1'b1, 1'b1, 8'h80, 1'b0}, 11};
        vt[9] = '{8'hFF, 2'b00, {1'b1, 8'hFF, 1'b0}, 10};

        sys_rst_n   = 1'b0;
        divisor     = 16'd3;
        parity_mode = 2'b00;
        tx_data     = 8'h00;
        tx_wr       = 1'b0;
        lb          = 1'b1;
        rx_drv      = 1'b1;
        repeat (3) tick();
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_rx_done", 32'(rx_done), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_errs", 32'({rx_frame_err, rx_parity_err}), 32'd0);
        sys_rst_n = 1'b1;
        repeat (4) tick();

        // loopback frame table
        for (int i = 0; i < 10; i++) begin
            tx_data     = vt[i].data;
            parity_mode = vt[i].mode;
            tx_wr       = 1'b1;
            tick();
            tx_wr = 1'b0;
            watch_tx(vt[i].frame, vt[i].nb, 48, vt[i].data, 1'b0);
            repeat (5) tick();
        end

        // divisor 0 behaves as 1: 16-cycle bits
        divisor     = 16'd0;
        tx_data     = 8'h4A;
        parity_mode = 2'b00;
        tx_wr       = 1'b1;
        tick();
        tx_wr = 1'b0;
        watch_tx({1'b1, 8'h4A, 1'b0}, 10, 16, 8'h4A, 1'b0);
        divisor = 16'd3;
        repeat (5) tick();

        // tx_wr held high across tx_done; mid-frame data/mode changes
        tx_data     = 8'h4A;
        parity_mode = 2'b00;
        tx_wr       = 1'b1;
        tick();
        watch_tx({1'b1, 8'h4A, 1'b0}, 10, 48, 8'h4A, 1'b1);
        tick();
        chk("b2b_start", 32'(uart_tx), 32'd0);
        chk("b2b_busy", 32'(tx_busy), 32'd1);
        tx_wr = 1'b0;
        for (int c = 1; c < 24; c++) tick();
        chk("b2b_bit0", 32'(uart_tx), 32'd0);
        repeat (24) tick();
        // second frame: 8'h35 with even parity (4 ones -> parity 0)
        for (int b = 1; b < 11; b++) begin
            repeat (24) tick();
            if (b == 9 || b == 5)
                chk($sformatf("b2b_bit%0d", b), 32'(uart_tx),
                    32'(b == 9 ? 0 : 1));
            repeat (24) tick();
        end
        chk("b2b_rx_word", 32'(rx_last), 32'h35);
        chk("b2b_rx_perr", 32'(rx_pe), 32'd0);
        repeat (5) tick();

        // parity error: A5 even with parity bit inverted
        lb          = 1'b0;
        rx_drv      = 1'b1;
        parity_mode = 2'b01;
        repeat (5) tick();
        rx0 = rx_cnt;
        drive_rx({1'b1, 1'b1, 8'hA5, 1'b0}, 11);
        repeat (20) tick();
        chk("perr_done_n", 32'(rx_cnt - rx0), 32'd1);
        chk("perr_flag", 32'(rx_pe), 32'd1);
        chk("perr_ferr", 32'(rx_fe), 32'd0);
        chk("perr_word", 32'(rx_last), 32'hA5);

        // frame error then 200-cycle break
        parity_mode = 2'b00;
        rx0 = rx_cnt;
        drive_rx({1'b0, 8'h3C, 1'b0}, 10);
        repeat (200) tick();
        chk("ferr_done_low", 32'(rx_cnt - rx0), 32'd1);
        rx_drv = 1'b1;
        repeat (600) tick();
        chk("ferr_done_n", 32'(rx_cnt - rx0), 32'd1);
        chk("ferr_flag", 32'(rx_fe), 32'd1);
        chk("ferr_perr", 32'(rx_pe), 32'd0);
        chk("ferr_word", 32'(rx_last), 32'h3C);
        rx0 = rx_cnt;
        drive_rx({1'b1, 8'h5A, 1'b0}, 10);
        repeat (20) tick();
        chk("after_break_n", 32'(rx_cnt - rx0), 32'd1);
        chk("after_break_word", 32'(rx_last), 32'h5A);
        chk("after_break_ferr", 32'(rx_fe), 32'd0);

        // 4-cycle glitch is a false start
        rx0 = rx_cnt;
        rx_drv = 1'b0;
        repeat (4) tick();
        rx_drv = 1'b1;
        repeat (1000) tick();
        chk("glitch_no_done", 32'(rx_cnt - rx0), 32'd0);
        drive_rx({1'b1, 8'hC3, 1'b0}, 10);
        repeat (20) tick();
        chk("glitch_rearm_n", 32'(rx_cnt - rx0), 32'd1);
        chk("glitch_rearm_word", 32'(rx_last), 32'hC3);

        // reset in the middle of a data bit
        lb          = 1'b1;
        parity_mode = 2'b01;
        tx_data     = 8'h4A;
        tx_wr       = 1'b1;
        tick();
        tx_wr = 1'b0;
        repeat (48 * 3 + 10) tick();
        tx0 = tx_cnt;
        rx0 = rx_cnt;
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("mid_rst_busy", 32'(tx_busy), 32'd0);
        chk("mid_rst_rx_data", 32'(rx_data), 32'd0);
        repeat (3) tick();
        sys_rst_n = 1'b1;
        repeat (600) tick();
        chk("mid_rst_no_tx_done", 32'(tx_cnt - tx0), 32'd0);
        chk("mid_rst_no_rx_done", 32'(rx_cnt - rx0), 32'd0);
        parity_mode = 2'b10;
        tx_data     = 8'h4A;
        tx_wr       = 1'b1;
        tick();
        tx_wr = 1'b0;
        watch_tx({1'b1, 1'b0, 8'h4A, 1'b0}, 11, 48, 8'h4A, 1'b0);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
